// File: rtl/regbank_frame_ctrl_if.sv
// Bus-side bundle for regbank_frame_ctrl: frame input, readback port and bank interface.
// slave = controller view, master = surrounding system / bank view.
interface regbank_frame_ctrl_if;
    logic        frm_valid;
    logic        frm_ready;
    logic [11:0] frm_data;
    logic [3:0]  frm_addr;
    logic        clr;
    logic        rd_req;
    logic [2:0]  rd_sel;
    logic        rd_gnt;
    logic        rd_valid;
    logic [7:0]  rd_data;
    logic        rd_err;
    logic        rb_we;
    logic [2:0]  rb_sel;
    logic [7:0]  rb_wdata;
    logic        rb_re;
    logic [7:0]  rb_rdata;
    logic        ack;
    logic        nack;
    logic        full;
    logic [2:0]  count;

    modport slave (
        input  frm_valid, frm_data, frm_addr, clr, rd_req, rd_sel, rb_rdata,
        output frm_ready, rd_gnt, rd_valid, rd_data, rd_err,
               rb_we, rb_sel, rb_wdata, rb_re, ack, nack, full, count
    );

    modport master (
        output frm_valid, frm_data, frm_addr, clr, rd_req, rd_sel, rb_rdata,
        input  frm_ready, rd_gnt, rd_valid, rd_data, rd_err,
               rb_we, rb_sel, rb_wdata, rb_re, ack, nack, full, count
    );
endinterface

// File: rtl/regbank_frame_ctrl.sv
// Frame checker / first-free filler for the a,b,c,d,h,l register bank,
// with round-robin arbitration between frame writes and readback requests.
module regbank_frame_ctrl #(
    parameter logic [3:0]  DEV_ADDR = 4'b0001,
    parameter int unsigned NREG     = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    regbank_frame_ctrl_if.slave   bus
);

    typedef enum logic [2:0] {IDLE, CHECK, WRITE, NACK, RD_ISSUE, RD_WAIT} state_t;
    typedef enum logic {G_FRAME, G_READ} gnt_t;

    state_t          state, state_d;
    gnt_t            last_gnt;
    logic [NREG-1:0] valid, valid_d;
    logic [11:0]     frm_q;
    logic [3:0]      addr_q;
    logic [2:0]      sel_q, target_q, free_idx, cnt_d, count_q;
    logic            full_q, found, frm_go, rd_go, frm_ok, rd_hit;
    logic [7:0]      valid_ext;

    // Tie between a frame and a read goes to whichever side lost the last grant.
    always_comb begin
        frm_go = bus.frm_valid && (!bus.rd_req || last_gnt == G_READ);
        rd_go  = bus.rd_req && (!bus.frm_valid || last_gnt == G_FRAME);
    end

    always_comb begin
        frm_ok = frm_q[0] && frm_q[11] && (addr_q == DEV_ADDR) && !full_q;
        valid_ext = '0;
        valid_ext[NREG-1:0] = valid;
        rd_hit = valid_ext[sel_q];
    end

    always_comb begin
        free_idx = '0;
        found    = 1'b0;
        for (int unsigned i = 0; i < NREG; i++) begin
            if (!found && !valid[i]) begin
                free_idx = 3'(i);
                found    = 1'b1;
            end
        end
    end

    always_comb begin
        valid_d = valid;
        if (state == IDLE && bus.clr)
            valid_d = '0;
        else if (state == WRITE)
            valid_d[target_q] = 1'b1;
        cnt_d = '0;
        for (int unsigned i = 0; i < NREG; i++)
            cnt_d = cnt_d + 3'(valid_d[i]);
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_d;
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE: begin
                if (!bus.clr) begin
                    if (frm_go)
                        state_d = CHECK;
                    else if (rd_go)
                        state_d = RD_ISSUE;
                end
            end
            CHECK:    state_d = frm_ok ? WRITE : NACK;
            WRITE:    state_d = IDLE;
            NACK:     state_d = IDLE;
            RD_ISSUE: state_d = RD_WAIT;
            RD_WAIT:  state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.frm_ready = 1'b0;
        bus.rd_gnt    = 1'b0;
        bus.rd_valid  = 1'b0;
        bus.rd_data   = '0;
        bus.rd_err    = 1'b0;
        bus.rb_we     = 1'b0;
        bus.rb_sel    = '0;
        bus.rb_wdata  = '0;
        bus.rb_re     = 1'b0;
        bus.ack       = 1'b0;
        bus.nack      = 1'b0;
        // Outputs are held quiet while rst is high so an aborted write never strobes the bank.
        if (!rst) begin
            case (state)
                IDLE: begin
                    if (!bus.clr) begin
                        bus.frm_ready = !rd_go;
                        bus.rd_gnt    = rd_go;
                    end
                end
                WRITE: begin
                    bus.rb_we    = 1'b1;
                    bus.rb_sel   = target_q;
                    bus.rb_wdata = frm_q[9:2];
                    bus.ack      = 1'b1;
                end
                NACK: bus.nack = 1'b1;
                RD_ISSUE: begin
                    bus.rb_re  = 1'b1;
                    bus.rb_sel = sel_q;
                end
                RD_WAIT: begin
                    bus.rd_valid = 1'b1;
                    bus.rd_err   = !rd_hit;
                    bus.rd_data  = rd_hit ? bus.rb_rdata : 8'h00;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid    <= '0;
            last_gnt <= G_READ;
            frm_q    <= '0;
            addr_q   <= '0;
            sel_q    <= '0;
            target_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
        end else begin
            valid   <= valid_d;
            count_q <= cnt_d;
            full_q  <= &valid_d;
            if (state == IDLE && !bus.clr) begin
                if (frm_go) begin
                    frm_q    <= bus.frm_data;
                    addr_q   <= bus.frm_addr;
                    last_gnt <= G_FRAME;
                end else if (rd_go) begin
                    sel_q    <= bus.rd_sel;
                    last_gnt <= G_READ;
                end
            end
            if (state == CHECK)
                target_q <= free_idx;
        end
    end

    assign bus.count = count_q;
    assign bus.full  = full_q;

endmodule

// File: tb/tb_regbank_frame_ctrl.sv
// Directed self-checking bench for regbank_frame_ctrl, with a simple 8-entry bank model
// answering rb_re one cycle later.
module tb_regbank_frame_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_assert = 0;
    int   n_fail   = 0;
    logic [7:0] mem [0:7];

    regbank_frame_ctrl_if bus ();

    regbank_frame_ctrl #(.DEV_ADDR(4'b0001), .NREG(6)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        for (int i = 0; i < 8; i++) mem[i] = 8'h00;
    end

    always @(posedge clk) begin
        if (bus.rb_we) mem[bus.rb_sel] <= bus.rb_wdata;
        if (bus.rb_re) bus.rb_rdata <= mem[bus.rb_sel];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge with the controller in IDLE; returns at T+3 (IDLE again).
    task automatic send_frame(input logic [7:0] b, input logic [3:0] a, input logic s,
                              input logic p, input logic exp_ack, input logic [2:0] exp_sel,
                              input logic [2:0] exp_cnt);
        bus.frm_valid = 1'b1;
        bus.frm_data  = {p, 1'b0, b, 1'b0, s};
        bus.frm_addr  = a;
        #1;
        chk("frm_ready_T", bus.frm_ready, 1);
        @(negedge clk);
        bus.frm_valid = 1'b0;
        #1;
        chk("frm_ready_T1", bus.frm_ready, 0);
        chk("ack_T1", bus.ack, 0);
        @(negedge clk);
        #1;
        chk("ack_T2", bus.ack, exp_ack);
        chk("nack_T2", bus.nack, !exp_ack);
        chk("rb_we_T2", bus.rb_we, exp_ack);
        if (exp_ack) begin
            chk("rb_sel_T2", bus.rb_sel, exp_sel);
            chk("rb_wdata_T2", bus.rb_wdata, b);
        end
        @(negedge clk);
        #1;
        chk("frm_ready_T3", bus.frm_ready, 1);
        chk("count_T3", bus.count, exp_cnt);
        chk("full_T3", bus.full, exp_cnt == 3'd6);
    endtask

    task automatic do_read(input logic [2:0] sel, input logic exp_err, input logic [7:0] exp_data);
        bus.rd_req = 1'b1;
        bus.rd_sel = sel;
        #1;
        chk("rd_gnt_T", bus.rd_gnt, 1);
        chk("frm_ready_rdT", bus.frm_ready, 0);
        @(negedge clk);
        bus.rd_req = 1'b0;
        #1;
        chk("rb_re_T1", bus.rb_re, 1);
        chk("rb_sel_T1", bus.rb_sel, sel);
        chk("rd_valid_T1", bus.rd_valid, 0);
        @(negedge clk);
        #1;
        chk("rd_valid_T2", bus.rd_valid, 1);
        chk("rd_err_T2", bus.rd_err, exp_err);
        chk("rd_data_T2", bus.rd_data, exp_data);
        @(negedge clk);
        #1;
        chk("rd_valid_T3", bus.rd_valid, 0);
    endtask

    initial begin
        bus.frm_valid = 1'b0;
        bus.frm_data  = '0;
        bus.frm_addr  = '0;
        bus.clr       = 1'b0;
        bus.rd_req    = 1'b0;
        bus.rd_sel    = '0;
        bus.rb_rdata  = '0;

        // Reset state
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_frm_ready", bus.frm_ready, 1);
        chk("rst_count", bus.count, 0);
        chk("rst_full", bus.full, 0);
        chk("rst_ack", bus.ack, 0);
        chk("rst_nack", bus.nack, 0);
        chk("rst_rb_we", bus.rb_we, 0);
        chk("rst_rb_re", bus.rb_re, 0);
        chk("rst_rd_valid", bus.rd_valid, 0);
        chk("rst_rd_data", bus.rd_data, 0);
        chk("rst_rd_gnt", bus.rd_gnt, 0);

        // Fill all six entries, then one frame too many
        for (int i = 0; i < 6; i++)
            send_frame(8'(8'h11 * (i + 1)), 4'h1, 1'b1, 1'b1, 1'b1, 3'(i), 3'(i + 1));
        send_frame(8'h77, 4'h1, 1'b1, 1'b1, 1'b0, 3'd0, 3'd6);

        // Readback: valid entry, out-of-range entry
        do_read(3'd2, 1'b0, 8'h33);
        do_read(3'd6, 1'b1, 8'h00);

        // Clear, then read an invalidated entry
        bus.clr = 1'b1;
        #1;
        chk("clr_frm_ready", bus.frm_ready, 0);
        @(negedge clk);
        bus.clr = 1'b0;
        #1;
        chk("clr_count", bus.count, 0);
        chk("clr_full", bus.full, 0);
        do_read(3'd0, 1'b1, 8'h00);

        // Malformed frames, then a good one refills entry 0
        send_frame(8'h81, 4'b0010, 1'b1, 1'b1, 1'b0, 3'd0, 3'd0);
        send_frame(8'h82, 4'h1, 1'b0, 1'b1, 1'b0, 3'd0, 3'd0);
        send_frame(8'h83, 4'h1, 1'b1, 1'b0, 1'b0, 3'd0, 3'd0);
        send_frame(8'h99, 4'h1, 1'b1, 1'b1, 1'b1, 3'd0, 3'd1);
        chk("mem0_refill", 32'(mem[0]), 32'h99);

        // Frame stream and read request held together from reset
        rst           = 1'b1;
        bus.frm_valid = 1'b1;
        bus.frm_data  = {1'b1, 1'b0, 8'hA5, 1'b0, 1'b1};
        bus.frm_addr  = 4'h1;
        bus.rd_req    = 1'b1;
        bus.rd_sel    = 3'd0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        for (int c = 0; c < 12; c++) begin
            chk("rr_frame_grant", bus.frm_valid && bus.frm_ready, (c % 6) == 0);
            chk("rr_read_grant", bus.rd_gnt, (c % 6) == 3);
            chk("rr_exclusive", bus.rd_gnt && bus.frm_ready, 0);
            @(negedge clk);
            #1;
        end
        bus.frm_valid = 1'b0;
        bus.rd_req    = 1'b0;
        #1;
        chk("rr_count", bus.count, 2);

        // Reset while a good frame is in CHECK
        bus.frm_valid = 1'b1;
        bus.frm_data  = {1'b1, 1'b0, 8'hC3, 1'b0, 1'b1};
        bus.frm_addr  = 4'h1;
        #1;
        chk("abort_accept", bus.frm_ready, 1);
        @(negedge clk);
        rst           = 1'b1;
        bus.frm_valid = 1'b0;
        #1;
        chk("abort_rb_we_check", bus.rb_we, 0);
        @(negedge clk);
        #1;
        chk("abort_ack", bus.ack, 0);
        chk("abort_rb_we", bus.rb_we, 0);
        rst = 1'b0;
        #1;
        chk("abort_frm_ready", bus.frm_ready, 1);
        chk("abort_count", bus.count, 0);
        chk("abort_full", bus.full, 0);
        @(negedge clk);
        #1;
        chk("abort_ack_late", bus.ack, 0);
        chk("abort_mem2", 32'(mem[2]), 32'h33);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
